// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory model answering processor read/write strobes.
// Latency: ready pulses WAIT_STATES+1 edges after the accepting edge; one access per WAIT_STATES+3 cycles.
// Backpressure: strobes are level requests held until ready; a strobe still high after ready parks the FSM in HOLD.
module mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iMemAddr,
  input  logic [31:0] iMemData,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  output logic [31:0] oMemData,
  output logic        oMemRdy,
  output logic        oMemErr
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic           rdy_q, rdy_d;
  logic           err_q, err_d;

  logic [31:0]          mem [DEPTH];
  logic                 mem_we;
  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;

  // Range and index are taken from the latched address, never from the live bus.
  assign idx      = addr_q[ADDR_BITS-1:0];
  assign in_range = (addr_q[31:ADDR_BITS] == '0);

  // Next-state, request latching and access resolution on the final wait cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iMemRead || iMemWrite) begin
          addr_d  = iMemAddr;
          wdata_d = iMemData;
          rd_d    = iMemRead;
          wr_d    = iMemWrite;
          cnt_d   = WS_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access happens on the edge that raises ready, so data is valid for the whole ready cycle.
          rdy_d   = 1'b1;
          state_d = ST_RESP;
          if (rd_q && wr_q) begin
            err_d = 1'b1;
          end else if (!in_range) begin
            err_d = 1'b1;
            if (rd_q) begin
              rdata_d = 32'd0;
            end
          end else if (rd_q) begin
            rdata_d = mem[idx];
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = (iMemRead || iMemWrite) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        // The old request must fully drop before a new one can be accepted.
        if (!iMemRead && !iMemWrite) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any in-flight transaction.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // Storage array is not reset; a reset forces IDLE so no write can be pending.
  always_ff @(posedge iClk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign oMemData = rdata_q;
  assign oMemRdy  = rdy_q;
  assign oMemErr  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AB = 10;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        err  [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(2)) u_ws2 (
    .iClk(clk), .nRst(nrst),
    .iMemAddr(addr[0]), .iMemData(wdat[0]), .iMemRead(rd[0]), .iMemWrite(wr[0]),
    .oMemData(rdat[0]), .oMemRdy(rdy[0]), .oMemErr(err[0])
  );

  mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(0)) u_ws0 (
    .iClk(clk), .nRst(nrst),
    .iMemAddr(addr[1]), .iMemData(wdat[1]), .iMemRead(rd[1]), .iMemWrite(wr[1]),
    .oMemData(rdat[1]), .oMemRdy(rdy[1]), .oMemErr(err[1])
  );

  int          total = 0;
  int          bad   = 0;
  int          ws [2];
  logic [31:0] mdl [2][16];
  logic [31:0] exp_dat [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One transaction, starting and ending at a falling edge. hold = extra cycles the
  // strobe stays high after ready; drop = sample index in WAIT at which the strobe drops (-1 none).
  task automatic xact(input int s, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input int hold, input int drop);
    logic [31:0] prev;
    logic [31:0] e_dat;
    logic        e_err;
    prev  = exp_dat[s];
    e_dat = prev;
    e_err = 1'b0;
    if (r && w) begin
      e_err = 1'b1;
    end else if ((a >> AB) != 32'd0) begin
      e_err = 1'b1;
      if (r) e_dat = 32'd0;
    end else if (r) begin
      e_dat = mdl[s][a[3:0]];
    end else begin
      mdl[s][a[3:0]] = d;
    end
    addr[s] = a; wdat[s] = d; rd[s] = r; wr[s] = w;
    for (int k = 0; k <= ws[s] + 1; k++) begin
      @(negedge clk);
      if (k < ws[s] + 1) begin
        check("rdy_wait", rdy[s], 0);
        check("dat_wait", rdat[s], prev);
        addr[s] = $urandom;
        wdat[s] = $urandom;
        if (k == drop) begin rd[s] = 1'b0; wr[s] = 1'b0; end
      end else begin
        check("rdy_resp", rdy[s], 1);
        check("err_resp", err[s], e_err);
        check("dat_resp", rdat[s], e_dat);
      end
    end
    exp_dat[s] = e_dat;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rdy_hold", rdy[s], 0);
    end
    rd[s] = 1'b0; wr[s] = 1'b0;
    @(negedge clk);
    check("rdy_after", rdy[s], 0);
  endtask

  initial begin
    ws[0] = 2; ws[1] = 0;
    exp_dat[0] = 32'd0; exp_dat[1] = 32'd0;
    for (int s = 0; s < 2; s++) begin
      addr[s] = 32'd0; wdat[s] = 32'd0; rd[s] = 1'b0; wr[s] = 1'b0;
    end
    nrst = 1'b0;
    #3;
    for (int s = 0; s < 2; s++) begin
      check("rst_rdy", rdy[s], 0);
      check("rst_err", err[s], 0);
      check("rst_dat", rdat[s], 0);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Give the low 16 words a known value in both instances.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        xact(s, 1'b0, 1'b1, 32'(i), $urandom, 0, -1);

    // Write then read, three-cycle latency.
    xact(0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 0, -1);
    xact(0, 1'b1, 1'b0, 32'h5, 32'h0, 0, -1);
    check("rd5_val", rdat[0], 32'hDEADBEEF);

    // Back-to-back with zero wait states.
    xact(1, 1'b0, 1'b1, 32'h1, 32'h11111111, 0, -1);
    xact(1, 1'b0, 1'b1, 32'h2, 32'h22222222, 0, -1);
    xact(1, 1'b1, 1'b0, 32'h2, 32'h0, 0, -1);
    xact(1, 1'b1, 1'b0, 32'h1, 32'h0, 0, -1);

    // Out of range: the write must not alias onto word 0.
    xact(0, 1'b0, 1'b1, 32'h400, 32'h12345678, 0, -1);
    xact(0, 1'b1, 1'b0, 32'h0, 32'h0, 0, -1);
    xact(0, 1'b1, 1'b0, 32'h400, 32'h0, 0, -1);

    // Read and write together: error, no write.
    xact(0, 1'b1, 1'b0, 32'h3, 32'h0, 0, -1);
    xact(0, 1'b1, 1'b1, 32'h3, 32'hA5A5A5A5, 0, -1);
    xact(0, 1'b1, 1'b0, 32'h3, 32'h0, 0, -1);

    // Strobe held past ready, then strobe dropped during WAIT.
    xact(0, 1'b1, 1'b0, 32'h5, 32'h0, 4, -1);
    xact(1, 1'b1, 1'b0, 32'h2, 32'h0, 4, -1);
    xact(0, 1'b1, 1'b0, 32'h1, 32'h0, 0, 1);
    xact(1, 1'b0, 1'b1, 32'h9, 32'h99999999, 0, 0);
    xact(1, 1'b1, 1'b0, 32'h9, 32'h0, 0, 0);

    // Reset during WAIT of a write aborts it.
    xact(0, 1'b1, 1'b0, 32'h5, 32'h0, 0, -1);
    addr[0] = 32'h7; wdat[0] = 32'hCAFEF00D; rd[0] = 1'b0; wr[0] = 1'b1;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("abort_dat", rdat[0], 0);
    check("abort_rdy", rdy[0], 0);
    check("abort_err", err[0], 0);
    wr[0] = 1'b0;
    exp_dat[0] = 32'd0;
    exp_dat[1] = 32'd0;
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_norrdy", rdy[0], 0);
    end
    xact(0, 1'b1, 1'b0, 32'h7, 32'h0, 0, -1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 120; i++) begin
      int          s;
      int          kind;
      int          mode;
      logic [31:0] a;
      bit          r;
      bit          w;
      s    = i % 2;
      kind = $urandom_range(0, 9);
      r    = (kind < 4) || (kind == 9);
      w    = (kind >= 4);
      if ($urandom_range(0, 5) == 0)
        a = (32'($urandom_range(1, 32'h3FFFFF)) << AB) | 32'($urandom_range(0, 15));
      else
        a = 32'($urandom_range(0, 15));
      mode = $urandom_range(0, 3);
      if (mode == 0)
        xact(s, r, w, a, $urandom, $urandom_range(1, 3), -1);
      else if (mode == 1)
        xact(s, r, w, a, $urandom, 0, $urandom_range(0, ws[s]));
      else
        xact(s, r, w, a, $urandom, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
